// File: rtl/fp_add_operand_stage_if.sv
// Handshake bundle between an operand producer, the operand stage, and the adder/bypass mux.
// The producer or bench side uses the master modport; the stage itself uses the slave modport.
interface fp_add_operand_stage_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_a;
  logic [WIDTH-1:0]         out_b;
  logic                     out_bypass;
  logic [WIDTH-1:0]         out_bypass_result;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_bypass, out_bypass_result, occupancy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_bypass, out_bypass_result, occupancy
  );
endinterface

// File: rtl/fp_add_operand_stage.sv
// Operand issue stage for the single-precision adder: classifies and swaps each pair on entry,
// then queues the canonical pair with its bypass decision in a small FIFO.
module fp_add_operand_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_add_operand_stage_if.slave bus
);
  localparam int               PW         = $clog2(DEPTH);
  localparam logic [PW:0]      FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] QNAN       = WIDTH'(32'h7FC0_0000);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bypass;
    logic [WIDTH-1:0] result;
  } entry_t;

  logic [WIDTH-1:0] ord [2];
  logic [1:0]       isZero;
  logic [1:0]       isInf;
  logic [1:0]       isNan;
  logic             signDiff;
  entry_t           inEntry;
  entry_t           headEntry;
  entry_t           lastEntry;
  entry_t           mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [PW:0]      count;
  logic             push;
  logic             pop;

  // ord[0] is the larger magnitude; ties keep the original order.
  always_comb begin
    ord[0] = bus.in_a;
    ord[1] = bus.in_b;
    if (bus.in_b[WIDTH-2:0] > bus.in_a[WIDTH-2:0]) begin
      ord[0] = bus.in_b;
      ord[1] = bus.in_a;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_class
      assign isZero[gi] = (ord[gi][30:23] == 8'h00);
      assign isInf[gi]  = (ord[gi][30:23] == 8'hFF) && (ord[gi][22:0] == 23'd0);
      assign isNan[gi]  = (ord[gi][30:23] == 8'hFF) && (ord[gi][22:0] != 23'd0);
    end
  endgenerate

  assign signDiff = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];

  always_comb begin
    inEntry.a      = ord[0];
    inEntry.b      = ord[1];
    inEntry.bypass = 1'b1;
    inEntry.result = '0;
    if (|isNan) begin
      inEntry.result = QNAN;
    end else if (isInf[0] && isInf[1] && signDiff) begin
      inEntry.result = QNAN;
    end else if (isInf[0]) begin
      inEntry.result = ord[0];
    end else if (isZero[0] && isZero[1]) begin
      inEntry.result = {bus.in_a[WIDTH-1] & bus.in_b[WIDTH-1], {(WIDTH-1){1'b0}}};
    end else if (isZero[1]) begin
      inEntry.result = ord[0];
    end else if ((ord[0][WIDTH-2:0] == ord[1][WIDTH-2:0]) && signDiff) begin
      inEntry.result = '0;
    end else begin
      inEntry.bypass = 1'b0;
    end
  end

  assign bus.in_ready  = (count < FULL_COUNT);
  assign bus.out_valid = (count != '0);
  assign bus.occupancy = count;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= inEntry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Keeps the outputs on the last popped pair while the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastEntry <= '0;
    end else if (pop) begin
      lastEntry <= mem[rdPtr];
    end
  end

  assign headEntry             = bus.out_valid ? mem[rdPtr] : lastEntry;
  assign bus.out_a             = headEntry.a;
  assign bus.out_b             = headEntry.b;
  assign bus.out_bypass        = headEntry.bypass;
  assign bus.out_bypass_result = headEntry.result;
endmodule

// File: tb/tb_fp_add_operand_stage.sv
// Randomised and directed bench for fp_add_operand_stage against a queue-based reference model.
module tb_fp_add_operand_stage;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        byp;
    logic [31:0] res;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pair_t modelQ[$];
  pair_t lastPop;

  fp_add_operand_stage_if #(.WIDTH(32), .DEPTH(DEPTH)) bus ();

  fp_add_operand_stage #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 zero/denormal, 1 normal, 2 infinity, 3 NaN
  function automatic int cls(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 0;
    if (x[30:23] != 8'hFF) return 1;
    return (x[22:0] == 0) ? 2 : 3;
  endfunction

  function automatic pair_t model(input logic [31:0] a, input logic [31:0] b);
    pair_t p;
    int    cb;
    int    cs;
    bit    opposite;
    if (b[30:0] > a[30:0]) begin p.a = b; p.b = a; end
    else                   begin p.a = a; p.b = b; end
    cb = cls(p.a);
    cs = cls(p.b);
    opposite = (a[31] != b[31]);
    p.byp = 1'b1;
    p.res = 32'h0;
    if (cb == 3 || cs == 3)                         p.res = 32'h7FC0_0000;
    else if (cb == 2 && cs == 2 && opposite)        p.res = 32'h7FC0_0000;
    else if (cb == 2)                               p.res = p.a;
    else if (cb == 0 && cs == 0)                    p.res = (a[31] && b[31]) ? 32'h8000_0000 : 32'h0;
    else if (cs == 0)                               p.res = p.a;
    else if (p.a[30:0] == p.b[30:0] && opposite)    p.res = 32'h0;
    else                                            p.byp = 1'b0;
    return p;
  endfunction

  function automatic logic [31:0] rndOp();
    int          k;
    logic [7:0]  e;
    logic [22:0] m;
    k = int'($urandom_range(0, 9));
    m = 23'($urandom);
    if (k == 0)      e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else             e = 8'($urandom_range(1, 254));
    if (k == 2 || (k == 1 && $urandom_range(0, 1) == 0)) m = '0;
    return {1'($urandom), e, m};
  endfunction

  task automatic drivePair();
    int k;
    bus.in_a = rndOp();
    k = int'($urandom_range(0, 7));
    if (k == 0)      bus.in_b = bus.in_a ^ 32'h8000_0000;
    else if (k == 1) bus.in_b = bus.in_a;
    else             bus.in_b = rndOp();
  endtask

  // Reference model update: decisions come from bench-driven inputs and the model's own fill level.
  always @(posedge clk or negedge rst_n) begin
    bit doPush;
    bit doPop;
    if (!rst_n) begin
      modelQ.delete();
      lastPop = '0;
    end else begin
      doPush = bus.in_valid && (modelQ.size() < DEPTH);
      doPop  = bus.out_ready && (modelQ.size() != 0);
      if (doPop)  lastPop = modelQ.pop_front();
      if (doPush) modelQ.push_back(model(bus.in_a, bus.in_b));
    end
  end

  always @(negedge clk) begin
    pair_t e;
    if (rst_n) begin
      e = (modelQ.size() != 0) ? modelQ[0] : lastPop;
      chk("in_ready",  32'(bus.in_ready),  32'(modelQ.size() < DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(modelQ.size() != 0));
      chk("occupancy", 32'(bus.occupancy), 32'(modelQ.size()));
      chk("out_a",     bus.out_a, e.a);
      chk("out_b",     bus.out_b, e.b);
      chk("bypass",    32'(bus.out_bypass), 32'(e.byp));
      chk("bypass_result", bus.out_bypass_result, e.res);
    end
  end

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expA, input logic [31:0] expB,
                          input logic expByp, input logic [31:0] expRes);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    chk({name, " a"}, bus.out_a, expA);
    chk({name, " b"}, bus.out_b, expB);
    chk({name, " byp"}, 32'(bus.out_bypass), 32'(expByp));
    chk({name, " res"}, bus.out_bypass_result, expRes);
    $display("directed %s: a=%08h b=%08h -> out_a=%08h out_b=%08h byp=%0d res=%08h",
             name, a, b, bus.out_a, bus.out_b, bus.out_bypass, bus.out_bypass_result);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.out_valid) begin
      errors++;
      $display("FAIL drain timeout: out_valid still %0d after %0d cycles", bus.out_valid, n);
    end
  endtask

  initial begin
    pair_t p;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Pin the model against hand-computed results.
    p = model(32'h3F80_0000, 32'h4000_0000);
    chk("model swap a", p.a, 32'h4000_0000);
    chk("model swap byp", 32'(p.byp), 32'd0);
    p = model(32'h4049_0FDB, 32'hC049_0FDB); chk("model cancel", {31'd0, p.byp} ^ p.res, 32'd1);
    p = model(32'h7F80_0000, 32'hFF80_0000); chk("model inf-inf", p.res, 32'h7FC0_0000);
    p = model(32'h7F80_0000, 32'h3F80_0000); chk("model inf+1", p.res, 32'h7F80_0000);
    p = model(32'h8000_0000, 32'h8000_0000); chk("model -0+-0", p.res, 32'h8000_0000);
    p = model(32'h0000_0001, 32'h3F80_0000); chk("model denorm", p.res, 32'h3F80_0000);
    p = model(32'h7FC0_1234, 32'h3F80_0000); chk("model nan", p.res, 32'h7FC0_0000);

    repeat (3) @(negedge clk);
    chk("reset occupancy", 32'(bus.occupancy), 32'd0);
    chk("reset in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_a",     bus.out_a, 32'd0);
    chk("reset result",    bus.out_bypass_result, 32'd0);
    rst_n = 1'b1;

    directed("swap",   32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0, 32'h0);
    directed("cancel", 32'h4049_0FDB, 32'hC049_0FDB, 32'h4049_0FDB, 32'hC049_0FDB, 1'b1, 32'h0);
    directed("infinf", 32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7FC0_0000);
    directed("inf1",   32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000);
    directed("negz",   32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000);
    directed("denorm", 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0001, 1'b1, 32'h3F80_0000);

    // Full and backpressure
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drivePair();
      @(negedge clk);
    end
    chk("full in_ready", 32'(bus.in_ready), 32'd0);
    chk("full occupancy", 32'(bus.occupancy), 32'd4);
    drivePair();
    @(negedge clk);
    chk("held occupancy", 32'(bus.occupancy), 32'd4);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("first pop occupancy", 32'(bus.occupancy), 32'd3);
    chk("first pop in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("fifth accepted occupancy", 32'(bus.occupancy), 32'd3);
    $display("backpressure: occupancy=%0d after fifth accepted", bus.occupancy);
    drain();

    // Reset mid-burst
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drivePair();
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("burst occupancy", 32'(bus.occupancy), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("midreset occupancy", 32'(bus.occupancy), 32'd0);
    chk("midreset out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset in_ready",  32'(bus.in_ready),  32'd1);
    chk("midreset out_b",     bus.out_b, 32'd0);
    $display("mid-burst reset: occupancy=%0d out_valid=%0d", bus.occupancy, bus.out_valid);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drivePair();
      @(negedge clk);
      chk("stream occupancy", 32'(bus.occupancy), 32'd1);
      $display("stream %0d: out_a=%08h out_b=%08h byp=%0d res=%08h",
               i, bus.out_a, bus.out_b, bus.out_bypass, bus.out_bypass_result);
    end
    drain();

    // Random handshake
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drivePair();
      @(negedge clk);
    end
    drain();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
